// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin sequencing front-end for a shared combinational ALU
//
// Two requesters present ALU operations over valid/ready handshakes. A
// round-robin grant picks one, its operands are registered and driven to
// the external ALU, and the ALU result and flags are captured one cycle
// later. They are then held on the response channel until consumed.
//
// Parameters:
//   WIDTH   operand/result width
//   CTRL_W  ALU control-code width
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   req0_valid/ready/ctrl/a/b       requester 0 handshake and payload
//   req1_valid/ready/ctrl/a/b       requester 1 handshake and payload
//   alu_ctrl, alu_a, alu_b          registered operands to the ALU
//   alu_out, alu_carry, alu_zero    ALU result and flags
//   rsp_valid, rsp_ready            response handshake
//   rsp_id                          index of the requester being answered
//   rsp_data, rsp_carry, rsp_zero   captured result and flags
//   rsp_err                         op code was rejected
//
// Configuration macro: ALU_ARB_CTRL_CHECK_EN
//   defined   - codes above SLT (1001..1111) are accepted but replaced by
//               AND on the ALU; the response is data=0, carry=0, zero=1, err=1
//   undefined - every code is forwarded unchanged; rsp_err is tied low

module alu_arbiter #(
    parameter int WIDTH  = 6,
    parameter int CTRL_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [CTRL_W-1:0] req0_ctrl,
    input  logic [WIDTH-1:0]  req0_a,
    input  logic [WIDTH-1:0]  req0_b,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [CTRL_W-1:0] req1_ctrl,
    input  logic [WIDTH-1:0]  req1_a,
    input  logic [WIDTH-1:0]  req1_b,

    output logic [CTRL_W-1:0] alu_ctrl,
    output logic [WIDTH-1:0]  alu_a,
    output logic [WIDTH-1:0]  alu_b,
    input  logic [WIDTH-1:0]  alu_out,
    input  logic              alu_carry,
    input  logic              alu_zero,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [WIDTH-1:0]  rsp_data,
    output logic              rsp_carry,
    output logic              rsp_zero,
    output logic              rsp_err
);

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] EXEC = 2'b01;
    localparam logic [1:0] RESP = 2'b10;

    logic [1:0]        state;
    logic              last_gnt;

    logic [CTRL_W-1:0] op_ctrl;
    logic [WIDTH-1:0]  op_a;
    logic [WIDTH-1:0]  op_b;
    logic              op_id;

    logic [WIDTH-1:0]  rsp_data_q;
    logic              rsp_carry_q;
    logic              rsp_zero_q;
    logic              rsp_valid_q;
    logic              rsp_id_q;

    // ------------------------------------------------------------------
    // Grant: a lone requester always wins; on a tie the requester that
    // was not granted last time wins. Ready is only offered in IDLE and
    // only to a requester that is actually asking, so the two readies are
    // mutually exclusive by construction.
    // ------------------------------------------------------------------
    logic grant0;
    logic grant1;
    logic in_idle;

    assign in_idle = (state == IDLE);
    assign grant0  = req0_valid & (~req1_valid | last_gnt);
    assign grant1  = req1_valid & (~req0_valid | ~last_gnt);

    assign req0_ready = in_idle & grant0;
    assign req1_ready = in_idle & grant1;

    // Ready implies valid, so either ready alone marks a transfer.
    logic              xfer;
    logic              xfer_id;
    logic [CTRL_W-1:0] sel_ctrl;
    logic [WIDTH-1:0]  sel_a;
    logic [WIDTH-1:0]  sel_b;

    assign xfer     = req0_ready | req1_ready;
    assign xfer_id  = req1_ready;
    assign sel_ctrl = xfer_id ? req1_ctrl : req0_ctrl;
    assign sel_a    = xfer_id ? req1_a    : req0_a;
    assign sel_b    = xfer_id ? req1_b    : req0_b;

    // ------------------------------------------------------------------
    // Op-code screening. The highest legal code is SLT (1000); anything
    // above it is rejected when checking is built in. The sanitised code
    // is what gets registered, so the ALU never sees an illegal code and
    // alu_ctrl stays stable for the whole operation.
    // ------------------------------------------------------------------
    logic [CTRL_W-1:0] ctrl_to_reg;
    logic              sel_illegal;

`ifdef ALU_ARB_CTRL_CHECK_EN
    localparam logic [CTRL_W-1:0] LAST_LEGAL = CTRL_W'(8);

    logic op_illegal;
    logic rsp_err_q;

    assign sel_illegal = (sel_ctrl > LAST_LEGAL);
    assign ctrl_to_reg = sel_illegal ? '0 : sel_ctrl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_illegal <= 1'b0;
        end else if (xfer) begin
            op_illegal <= sel_illegal;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_err_q <= 1'b0;
        end else if (state == EXEC) begin
            rsp_err_q <= op_illegal;
        end
    end

    assign rsp_err = rsp_err_q;
`else
    assign sel_illegal = 1'b0;
    assign ctrl_to_reg = sel_ctrl;
    assign rsp_err     = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Sequencer: IDLE -> EXEC on transfer, EXEC -> RESP unconditionally,
    // RESP -> IDLE when the response is consumed.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (xfer) state <= EXEC;
                EXEC:    state <= RESP;
                RESP:    if (rsp_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Grant pointer starts at 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt <= 1'b1;
        end else if (xfer) begin
            last_gnt <= xfer_id;
        end
    end

    // Operand registers only move on an accepting edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_ctrl <= '0;
            op_a    <= '0;
            op_b    <= '0;
            op_id   <= 1'b0;
        end else if (xfer) begin
            op_ctrl <= ctrl_to_reg;
            op_a    <= sel_a;
            op_b    <= sel_b;
            op_id   <= xfer_id;
        end
    end

    assign alu_ctrl = op_ctrl;
    assign alu_a    = op_a;
    assign alu_b    = op_b;

    // ------------------------------------------------------------------
    // Response capture at the end of EXEC; held through RESP.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] cap_data;
    logic             cap_carry;
    logic             cap_zero;

`ifdef ALU_ARB_CTRL_CHECK_EN
    assign cap_data  = op_illegal ? '0   : alu_out;
    assign cap_carry = op_illegal ? 1'b0 : alu_carry;
    assign cap_zero  = op_illegal ? 1'b1 : alu_zero;
`else
    assign cap_data  = alu_out;
    assign cap_carry = alu_carry;
    assign cap_zero  = alu_zero;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_data_q  <= '0;
            rsp_carry_q <= 1'b0;
            rsp_zero_q  <= 1'b0;
            rsp_id_q    <= 1'b0;
        end else if (state == EXEC) begin
            rsp_data_q  <= cap_data;
            rsp_carry_q <= cap_carry;
            rsp_zero_q  <= cap_zero;
            rsp_id_q    <= op_id;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
        end else if (state == EXEC) begin
            rsp_valid_q <= 1'b1;
        end else if ((state == RESP) && rsp_ready) begin
            rsp_valid_q <= 1'b0;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_carry = rsp_carry_q;
    assign rsp_zero  = rsp_zero_q;

endmodule
